// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline timing encodings (Tuse/Tnew) and mult/div latency defaults.
package cpu_pipe_pkg;
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W        = 4;

  // A source stalls when a producer in flight cannot forward before the consumer needs it.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] wreg_e, input logic [1:0] tnew_e,
                                      input logic [4:0] wreg_m, input logic [1:0] tnew_m);
    return (src != 5'd0) && (tuse != TUSE_NONE) &&
           (((src == wreg_e) && (tnew_e > tuse)) || ((src == wreg_m) && (tnew_m > tuse)));
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline operand/destination info in, stall/flush controls out.
interface hazard_ctrl_if;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [1:0]  rs_tuse_d;
  logic [1:0]  rt_tuse_d;
  logic [4:0]  wreg_e;
  logic [1:0]  tnew_e;
  logic [4:0]  wreg_m;
  logic [1:0]  tnew_m;
  logic        md_start_e;
  logic        md_div_e;
  logic        md_op_d;
  logic        stall_f;
  logic        stall_d;
  logic        flush_e;
  logic        md_busy;
  logic [31:0] stall_count;

  modport master (
    output rs_d, rt_d, rs_tuse_d, rt_tuse_d, wreg_e, tnew_e, wreg_m, tnew_m,
           md_start_e, md_div_e, md_op_d,
    input  stall_f, stall_d, flush_e, md_busy, stall_count
  );

  modport slave (
    input  rs_d, rt_d, rs_tuse_d, rt_tuse_d, wreg_e, tnew_e, wreg_m, tnew_m,
           md_start_e, md_div_e, md_op_d,
    output stall_f, stall_d, flush_e, md_busy, stall_count
  );
endinterface

// File: rtl/md_busy_counter.sv
// Mult/div busy countdown: reload on issue from E, count down to idle.
module md_busy_counter
  import cpu_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                busy_q;

  // A new issue always reloads, even mid-countdown: the latest latency wins.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = div_i ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler: Tuse/Tnew data hazards, mult/div busy interlock, stall counter.
module hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);
  logic        md_busy;
  logic        hz_rs, hz_rt, hz_md, stall;
  logic [31:0] stall_count_q;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (hif.md_start_e),
    .div_i   (hif.md_div_e),
    .busy_o  (md_busy)
  );

  always_comb begin
    hz_rs = src_hazard(hif.rs_d, hif.rs_tuse_d, hif.wreg_e, hif.tnew_e, hif.wreg_m, hif.tnew_m);
    hz_rt = src_hazard(hif.rt_d, hif.rt_tuse_d, hif.wreg_e, hif.tnew_e, hif.wreg_m, hif.tnew_m);
    // The issuing cycle itself blocks a dependent md op, before busy is visible.
    hz_md = hif.md_op_d & (md_busy | hif.md_start_e);
    stall = ~reset & (hz_rs | hz_rt | hz_md);
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_count_q <= '0;
    else if (stall && (stall_count_q != '1))
      stall_count_q <= stall_count_q + 32'd1;
  end

  assign hif.stall_f     = stall;
  assign hif.stall_d     = stall;
  assign hif.flush_e     = stall;
  assign hif.md_busy     = md_busy;
  assign hif.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of single-cycle hazard vectors plus multi-cycle sequences.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  typedef struct packed {
    logic [4:0] rs; logic [1:0] rs_tu;
    logic [4:0] rt; logic [1:0] rt_tu;
    logic [4:0] we; logic [1:0] te;
    logic [4:0] wm; logic [1:0] tm;
    logic md_op;
    logic stall;
  } vec_t;

  typedef struct {
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[14];
  logic [31:0] cnt_m = 32'd0;
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(input int rs, input int rs_tu, input int rt, input int rt_tu,
                              input int we, input int te, input int wm, input int tm,
                              input int md_op, input int stall);
    vec_t v;
    v.rs = 5'(rs); v.rs_tu = 2'(rs_tu);
    v.rt = 5'(rt); v.rt_tu = 2'(rt_tu);
    v.we = 5'(we); v.te = 2'(te);
    v.wm = 5'(wm); v.tm = 2'(tm);
    v.md_op = md_op[0]; v.stall = stall[0];
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: no expected entry, got 0 expected 1");
      return;
    end
    e = sbq.pop_front();
    cmp({e.name, ".stall_f"},     32'(hif.stall_f),   32'(e.stall));
    cmp({e.name, ".stall_d"},     32'(hif.stall_d),   32'(e.stall));
    cmp({e.name, ".flush_e"},     32'(hif.flush_e),   32'(e.stall));
    cmp({e.name, ".md_busy"},     32'(hif.md_busy),   32'(e.busy));
    cmp({e.name, ".stall_count"}, hif.stall_count,    e.cnt);
  endtask

  // One cycle: drive at negedge, queue expectation, advance count model, compare.
  task automatic drive(input vec_t v, input logic ms, input logic md, input logic rst,
                       input logic busy_exp, input string nm);
    @(negedge clk);
    reset          = rst;
    hif.rs_d       = v.rs;  hif.rs_tuse_d = v.rs_tu;
    hif.rt_d       = v.rt;  hif.rt_tuse_d = v.rt_tu;
    hif.wreg_e     = v.we;  hif.tnew_e    = v.te;
    hif.wreg_m     = v.wm;  hif.tnew_m    = v.tm;
    hif.md_op_d    = v.md_op;
    hif.md_start_e = ms;
    hif.md_div_e   = md;
    sbq.push_back('{v.stall, busy_exp, cnt_m, nm});
    if (rst) cnt_m = 32'd0;
    else if (v.stall && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
    #1 check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, lu, v;
    idle = mk(0,3, 0,3, 0,0, 0,0, 0, 0);
    lu   = mk(8,1, 0,3, 8,2, 0,0, 0, 1);

    tbl[0]  = lu;                                // load-use
    tbl[1]  = mk(0,0,  0,3,  0,2,  0,0, 0, 0);   // register 0
    tbl[2]  = mk(5,1,  0,3,  5,1,  0,0, 0, 0);   // ALU -> E use forwards
    tbl[3]  = mk(5,0,  0,3,  5,1,  0,0, 0, 1);   // ALU -> branch
    tbl[4]  = mk(8,3,  0,3,  8,2,  0,0, 0, 0);   // rs unused
    tbl[5]  = mk(0,3,  9,0,  0,0,  9,1, 0, 1);   // rt load in M, branch use
    tbl[6]  = mk(0,3,  9,1,  0,0,  9,1, 0, 0);   // rt load in M, E use
    tbl[7]  = mk(7,0,  6,0,  8,2, 10,1, 0, 0);   // no register match
    tbl[8]  = mk(0,3,  0,3,  0,0,  0,0, 1, 0);   // md op, unit idle
    tbl[9]  = mk(0,3,  4,0,  4,0,  0,0, 0, 0);   // tnew_e 0
    tbl[10] = mk(3,0, 12,1, 12,2,  0,0, 0, 1);   // rt load-use
    tbl[11] = mk(6,0,  0,3,  0,0,  6,0, 0, 0);   // M result ready
    tbl[12] = mk(2,0, 31,1, 31,2,  2,1, 0, 1);   // rs via M and rt via E
    tbl[13] = mk(0,0,  0,0,  0,0,  0,1, 0, 0);   // register 0 against M

    // Reset gates stall even with a hazard present.
    v = lu; v.stall = 1'b0;
    drive(v, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
    drive(idle, 1'b0, 1'b0, 1'b1, 1'b0, "reset2");

    foreach (tbl[i]) drive(tbl[i], 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));
    drive(idle, 1'b0, 1'b0, 1'b0, 1'b0, "vec_cnt");

    // Load-use resolves after one bubble.
    drive(lu, 1'b0, 1'b0, 1'b0, 1'b0, "lu_c0");
    drive(mk(8,1, 0,3, 0,0, 8,1, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, "lu_c1");

    // Branch after load: two stalls.
    drive(mk(0,3, 9,0, 9,2, 0,0, 0, 1), 1'b0, 1'b0, 1'b0, 1'b0, "bl_c0");
    drive(mk(0,3, 9,0, 0,0, 9,1, 0, 1), 1'b0, 1'b0, 1'b0, 1'b0, "bl_c1");
    drive(mk(0,3, 9,0, 0,0, 0,0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, "bl_c2");

    // Div then mflo: start cycle plus ten busy cycles.
    drive(mk(0,3, 0,3, 0,0, 0,0, 1, 1), 1'b1, 1'b1, 1'b0, 1'b0, "div_c0");
    for (int i = 1; i <= 10; i++)
      drive(mk(0,3, 0,3, 0,0, 0,0, 1, 1), 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("div_c%0d", i));
    drive(mk(0,3, 0,3, 0,0, 0,0, 1, 0), 1'b0, 1'b0, 1'b0, 1'b0, "div_c11");

    // Reset two cycles into a mult countdown.
    drive(idle, 1'b1, 1'b0, 1'b0, 1'b0, "rm_c0");
    drive(idle, 1'b0, 1'b0, 1'b0, 1'b1, "rm_c1");
    drive(idle, 1'b0, 1'b0, 1'b0, 1'b1, "rm_c2");
    v = mk(8,1, 0,3, 8,2, 0,0, 1, 0);
    drive(v, 1'b0, 1'b0, 1'b1, 1'b1, "rm_rst");
    drive(mk(0,3, 0,3, 0,0, 0,0, 1, 0), 1'b0, 1'b0, 1'b0, 1'b0, "rm_after");

    // Saturation: preload one below max, then keep stalling.
    drive(idle, 1'b0, 1'b0, 1'b0, 1'b0, "sat_pre");
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1 release dut.stall_count_q;
    cnt_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) drive(lu, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("sat_c%0d", i));
    drive(idle, 1'b0, 1'b0, 1'b0, 1'b0, "sat_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
